mxu_job_arbiter: RTL and testbench

- Round-robin scheduler that shares one temporal_mxu matrix unit between NUM_REQ requesters.
- Accepts one job at a time (A, B operand matrices plus job id), latches the operands and pulses the MXU start.
- Waits for the MXU out_valid, captures the product and returns it on a valid/ready response channel, with timeout protection and a cycle count.
- Sits between the requester fabric and the single temporal_mxu instance.

---
 rtl/mxu_job_arbiter_if.sv | 38 +++
 rtl/mxu_job_arbiter.sv | 117 +++++++++++
 tb/tb_mxu_job_arbiter.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mxu_job_arbiter_if.sv
// rtl/mxu_job_arbiter_if.sv - requester, MXU and response signals of the job arbiter
interface mxu_job_arbiter_if #(
    parameter int NUM_REQ   = 4,
    parameter int DIM       = 16,
    parameter int BIT_WIDTH = 4,
    parameter int TIMEOUT   = 1024,
    parameter int ID_W      = $clog2(NUM_REQ),
    parameter int CYC_W     = $clog2(TIMEOUT + 1)
);
    logic [NUM_REQ-1:0]                                  req_valid;
    logic [NUM_REQ-1:0][DIM-1:0][DIM-1:0][BIT_WIDTH-1:0] req_a;
    logic [NUM_REQ-1:0][DIM-1:0][DIM-1:0][BIT_WIDTH-1:0] req_b;
    logic [NUM_REQ-1:0]                                  req_ready;
    logic                                                mxu_start;
    logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]              mxu_a;
    logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]              mxu_b;
    logic                                                mxu_out_valid;
    logic [DIM-1:0][DIM-1:0][2*BIT_WIDTH-1:0]            mxu_out;
    logic                                                rsp_valid;
    logic                                                rsp_ready;
    logic [ID_W-1:0]                                     rsp_id;
    logic [DIM-1:0][DIM-1:0][2*BIT_WIDTH-1:0]            rsp_data;
    logic                                                rsp_err;
    logic [CYC_W-1:0]                                    rsp_cycles;
    logic                                                busy;

    modport slave (
        input  req_valid, req_a, req_b, mxu_out_valid, mxu_out, rsp_ready,
        output req_ready, mxu_start, mxu_a, mxu_b, rsp_valid, rsp_id, rsp_data,
               rsp_err, rsp_cycles, busy
    );

    modport master (
        output req_valid, req_a, req_b, mxu_out_valid, mxu_out, rsp_ready,
        input  req_ready, mxu_start, mxu_a, mxu_b, rsp_valid, rsp_id, rsp_data,
               rsp_err, rsp_cycles, busy
    );
endinterface

// File: rtl/mxu_job_arbiter.sv
// rtl/mxu_job_arbiter.sv - round-robin job scheduler in front of a single temporal_mxu
module mxu_job_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DIM       = 16,
    parameter int BIT_WIDTH = 4,
    parameter int TIMEOUT   = 1024,
    parameter int ID_W      = $clog2(NUM_REQ),
    parameter int CYC_W     = $clog2(TIMEOUT + 1)
) (
    input  logic             clk,
    input  logic             reset,
    mxu_job_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, START, RUN, RESP} state_t;

    state_t                                   state, state_next;
    logic [ID_W-1:0]                          ptr;
    logic [ID_W-1:0]                          grant;
    logic                                     grant_found;
    int                                       idx;
    logic [NUM_REQ-1:0]                       req_ready_c;
    logic [CYC_W-1:0]                         cnt, cnt_inc;
    logic                                     timeout;
    logic [ID_W-1:0]                          id_q;
    logic [DIM-1:0][DIM-1:0][BIT_WIDTH-1:0]   a_q, b_q;
    logic [DIM-1:0][DIM-1:0][2*BIT_WIDTH-1:0] data_q;
    logic                                     err_q;
    logic [CYC_W-1:0]                         cyc_q;

    // First valid requester at or after the pointer, wrapping around.
    always_comb begin
        grant       = '0;
        grant_found = 1'b0;
        idx         = 0;
        for (int i = 0; i < NUM_REQ; i++) begin
            idx = (int'(ptr) + i) % NUM_REQ;
            if (!grant_found && bus.req_valid[idx]) begin
                grant_found = 1'b1;
                grant       = ID_W'(idx);
            end
        end
    end

    assign cnt_inc = (cnt == CYC_W'(TIMEOUT)) ? cnt : cnt + CYC_W'(1);
    assign timeout = (cnt_inc == CYC_W'(TIMEOUT));

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (grant_found) state_next = START;
            START:   state_next = RUN;
            RUN:     if (bus.mxu_out_valid || timeout) state_next = RESP;
            RESP:    if (bus.rsp_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        req_ready_c = '0;
        if (state == IDLE && grant_found) req_ready_c[grant] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            ptr    <= '0;
            cnt    <= '0;
            id_q   <= '0;
            a_q    <= '0;
            b_q    <= '0;
            data_q <= '0;
            err_q  <= 1'b0;
            cyc_q  <= '0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        a_q  <= bus.req_a[grant];
                        b_q  <= bus.req_b[grant];
                        id_q <= grant;
                    end
                end
                START: cnt <= '0;
                RUN: begin
                    cnt <= cnt_inc;
                    // A result arriving on the timeout cycle still counts as success.
                    if (bus.mxu_out_valid) begin
                        data_q <= bus.mxu_out;
                        err_q  <= 1'b0;
                        cyc_q  <= cnt_inc;
                    end else if (timeout) begin
                        data_q <= '0;
                        err_q  <= 1'b1;
                        cyc_q  <= CYC_W'(TIMEOUT);
                    end
                end
                RESP: begin
                    if (bus.rsp_ready)
                        ptr <= (id_q == ID_W'(NUM_REQ - 1)) ? '0 : id_q + ID_W'(1);
                end
                default: ;
            endcase
        end
    end

    assign bus.req_ready  = req_ready_c;
    assign bus.mxu_start  = (state == START);
    assign bus.mxu_a      = a_q;
    assign bus.mxu_b      = b_q;
    assign bus.rsp_valid  = (state == RESP);
    assign bus.rsp_id     = id_q;
    assign bus.rsp_data   = data_q;
    assign bus.rsp_err    = err_q;
    assign bus.rsp_cycles = cyc_q;
    assign bus.busy       = (state != IDLE);
endmodule

// File: tb/tb_mxu_job_arbiter.sv
// tb/tb_mxu_job_arbiter.sv - randomized self-checking bench for mxu_job_arbiter
module tb_mxu_job_arbiter;
    localparam int NR    = 4;
    localparam int DIM   = 2;
    localparam int BW    = 4;
    localparam int TO    = 16;
    localparam int CYC_W = $clog2(TO + 1);

    typedef logic [DIM-1:0][DIM-1:0][BW-1:0]   mat_t;
    typedef logic [DIM-1:0][DIM-1:0][2*BW-1:0] res_t;

    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    mxu_job_arbiter_if #(.NUM_REQ(NR), .DIM(DIM), .BIT_WIDTH(BW), .TIMEOUT(TO)) bus ();

    mxu_job_arbiter #(.NUM_REQ(NR), .DIM(DIM), .BIT_WIDTH(BW), .TIMEOUT(TO)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    int stub_delay;
    int stub_cnt;
    int acc;
    always_ff @(posedge clk) begin
        if (reset)                                    stub_cnt <= 0;
        else if (bus.mxu_start)                       stub_cnt <= 1;
        else if (stub_cnt != 0 && stub_cnt < 1000)    stub_cnt <= stub_cnt + 1;
    end
    assign bus.mxu_out_valid = (stub_delay != 0) && (stub_cnt == stub_delay);
    always_comb begin
        bus.mxu_out = '0;
        acc = 0;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                acc = 0;
                for (int k = 0; k < DIM; k++)
                    acc += int'($signed(bus.mxu_a[i][k])) * int'($signed(bus.mxu_b[k][j]));
                bus.mxu_out[i][j] = acc[2*BW-1:0];
            end
    end

    bit mon_bad = 1'b0;
    always @(negedge clk) begin
        if (!reset && ($countones(bus.req_ready) > 1 ||
                       (bus.mxu_start && (bus.rsp_valid || bus.req_ready != '0))))
            mon_bad = 1'b1;
    end

    int ma [NR][DIM][DIM];
    int mb [NR][DIM][DIM];
    int exp_ptr;
    int last_grant;
    res_t last_data;

    function automatic mat_t mat_of(input int r, input bit sel_b);
        mat_t m;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++)
                m[i][j] = sel_b ? BW'(mb[r][i][j]) : BW'(ma[r][i][j]);
        return m;
    endfunction

    function automatic res_t prod_of(input int r);
        res_t p;
        int   s;
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                s = 0;
                for (int k = 0; k < DIM; k++) s += ma[r][i][k] * mb[r][k][j];
                p[i][j] = (2*BW)'(s);
            end
        return p;
    endfunction

    function automatic int model_grant(input logic [NR-1:0] mask);
        for (int i = 0; i < NR; i++)
            if (mask[(exp_ptr + i) % NR]) return (exp_ptr + i) % NR;
        return -1;
    endfunction

    task automatic drive_req(input int r);
        bus.req_a[r] = mat_of(r, 1'b0);
        bus.req_b[r] = mat_of(r, 1'b1);
    endtask

    task automatic rand_mat(input int r);
        for (int i = 0; i < DIM; i++)
            for (int j = 0; j < DIM; j++) begin
                ma[r][i][j] = int'($urandom_range(15)) - 8;
                mb[r][i][j] = int'($urandom_range(15)) - 8;
            end
        drive_req(r);
    endtask

    task automatic do_job(input logic [NR-1:0] mask, input int delay, input int stall);
        int               eg, n, starts;
        logic [NR-1:0]    er;
        mat_t             ea, eb;
        res_t             ed;
        logic             eerr;
        logic [CYC_W-1:0] ecyc;
        bus.req_valid = mask;
        stub_delay    = delay;
        bus.rsp_ready = (stall == 0);
        #1;
        eg   = model_grant(mask);
        er   = NR'(1) << eg;
        ea   = mat_of(eg, 1'b0);
        eb   = mat_of(eg, 1'b1);
        eerr = (delay == 0) || (delay > TO);
        ecyc = eerr ? CYC_W'(TO) : CYC_W'(delay);
        ed   = eerr ? '0 : prod_of(eg);
        n = 0;
        while (bus.req_ready == '0 && n < 20) begin
            @(negedge clk); #1;
            n++;
        end
        chk("grant", bus.req_ready, er);
        last_grant = -1;
        for (int i = 0; i < NR; i++) if (bus.req_ready[i]) last_grant = i;
        @(negedge clk);
        chk("mxu_start", bus.mxu_start, 1'b1);
        chk("start_ready", bus.req_ready, 4'b0000);
        chk("mxu_a", bus.mxu_a, ea);
        chk("mxu_b", bus.mxu_b, eb);
        chk("busy", bus.busy, 1'b1);
        rand_mat(eg);
        n = 0;
        starts = 0;
        while (!bus.rsp_valid && n < TO + 10) begin
            @(negedge clk);
            n++;
            if (bus.mxu_start) starts++;
        end
        chk("rsp_valid", bus.rsp_valid, 1'b1);
        chk("rsp_latency", n, int'(ecyc) + 1);
        chk("extra_start", starts, 0);
        chk("rsp_id", int'(bus.rsp_id), eg);
        chk("rsp_err", bus.rsp_err, eerr);
        chk("rsp_cycles", bus.rsp_cycles, ecyc);
        chk("rsp_data", bus.rsp_data, ed);
        chk("held_mxu_a", bus.mxu_a, ea);
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("stall_valid", bus.rsp_valid, 1'b1);
            chk("stall_data", bus.rsp_data, ed);
            chk("stall_id", int'(bus.rsp_id), eg);
            chk("stall_ready", bus.req_ready, 4'b0000);
            chk("stall_start", bus.mxu_start, 1'b0);
        end
        last_data = bus.rsp_data;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        exp_ptr = (eg + 1) % NR;
        chk("rsp_done", bus.rsp_valid, 1'b0);
        chk("idle_busy", bus.busy, 1'b0);
        chk("monitor", mon_bad, 1'b0);
    endtask

    initial begin
        reset         = 1'b1;
        bus.req_valid = '0;
        bus.rsp_ready = 1'b0;
        stub_delay    = 5;
        exp_ptr       = 0;
        for (int r = 0; r < NR; r++) rand_mat(r);
        repeat (3) @(negedge clk);
        chk("rst_ready", bus.req_ready, 4'b0000);
        chk("rst_start", bus.mxu_start, 1'b0);
        chk("rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_rsp_data", bus.rsp_data, res_t'(0));
        chk("rst_rsp_cycles", bus.rsp_cycles, CYC_W'(0));
        chk("rst_mxu_a", bus.mxu_a, mat_t'(0));
        reset = 1'b0;

        ma[1] = '{'{1, 2}, '{3, 4}};
        mb[1] = '{'{1, 0}, '{0, 1}};
        drive_req(1);
        do_job(4'b0010, 5, 0);
        chk("identity_data", last_data, {8'h04, 8'h03, 8'h02, 8'h01});
        chk("identity_id", last_grant, 1);

        ma[1] = '{'{-1, 2}, '{0, -3}};
        mb[1] = '{'{2, 0}, '{1, 1}};
        drive_req(1);
        do_job(4'b0010, 5, 0);
        chk("signed_data", last_data, {8'hFD, 8'hFD, 8'h02, 8'h00});

        do_job(4'b1000, 3, 0);
        for (int i = 0; i < 8; i++) begin
            do_job(4'b1111, int'($urandom_range(1, 8)), 0);
            chk("rr_order", last_grant, i % NR);
        end

        do_job(4'b0100, 5, 20);

        do_job(4'b0001, 0, 0);
        do_job(4'b0001, TO, 0);
        do_job(4'b0010, TO + 1, 0);
        do_job(4'b0010, 1, 0);

        for (int i = 0; i < 20; i++)
            do_job(NR'($urandom_range(1, 15)), int'($urandom_range(0, 20)),
                   int'($urandom_range(0, 3)));

        do_job(4'b0100, 5, 0);
        bus.req_valid = 4'b0100;
        stub_delay    = 10;
        #1;
        for (int n = 0; n < 20 && bus.req_ready == '0; n++) begin
            @(negedge clk); #1;
        end
        repeat (3) @(negedge clk);
        reset         = 1'b1;
        bus.req_valid = '0;
        @(negedge clk);
        reset   = 1'b0;
        exp_ptr = 0;
        #1;
        chk("mid_rst_busy", bus.busy, 1'b0);
        chk("mid_rst_start", bus.mxu_start, 1'b0);
        chk("mid_rst_rsp_valid", bus.rsp_valid, 1'b0);
        chk("mid_rst_rsp_id", bus.rsp_id, 2'b00);
        chk("mid_rst_rsp_data", bus.rsp_data, res_t'(0));
        chk("mid_rst_rsp_err", bus.rsp_err, 1'b0);
        chk("mid_rst_mxu_a", bus.mxu_a, mat_t'(0));
        begin
            int seen;
            seen = 0;
            repeat (25) begin
                @(negedge clk);
                if (bus.rsp_valid || bus.busy) seen++;
            end
            chk("aborted_no_rsp", seen, 0);
        end
        do_job(4'b1111, 5, 0);
        chk("post_rst_grant", last_grant, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
